// File: rtl/depacketizer_ta.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : depacketizer_ta
// Description : Reassembles 1..4 NoC flits into one payload and splits it
//               into a data word and its slave tag, with the VC of the head
//               flit. Single-entry output holding register with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module depacketizer_ta #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_DATA       = 12,
    parameter int WIDTH_FLIT       = 36,
    parameter int PACKETIZER_WIDTH = 1,
    parameter int WIDTH_TAG        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_FLIT-1:0]       data_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_DATA-1:0]       data_out,
    output logic [WIDTH_TAG-1:0]        tag_out,
    output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        error_out
);

    // Head chunk is narrower than body chunks because it also carries dst.
    localparam int PH = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int PB = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
    localparam int PT = PH + (PACKETIZER_WIDTH - 1) * PB;
    // Storage always has room for one body chunk so the body write slice
    // stays in range even for single-flit packets.
    localparam int PR = PH + ((PACKETIZER_WIDTH > 1) ? (PACKETIZER_WIDTH - 1) : 1) * PB;
    localparam logic [1:0] K_LAST   = 2'(PACKETIZER_WIDTH - 1);
    localparam logic       HEAD_LAST = (PACKETIZER_WIDTH == 1);

    // Reject configurations whose flits cannot carry data plus tag.
    if ((WIDTH_DATA + WIDTH_TAG > PT) || (PACKETIZER_WIDTH < 1) || (PACKETIZER_WIDTH > 4)) begin : g_width_check
        $error("depacketizer_ta: payload too narrow or PACKETIZER_WIDTH out of 1..4");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t                      state, state_nxt;
    logic [1:0]                  k, k_nxt;
    logic [PR-1:0]               payload;
    logic [PR-1:0]               assembled;
    logic [VC_ADDRESS_WIDTH-1:0] vc_hold;
    logic [VC_ADDRESS_WIDTH-1:0] vc_pkt;
    logic                        out_full;
    logic                        store_head, store_body, load, err;
    int                          body_off;
    logic                        unused_asm;

    logic                        f_valid, f_head, f_tail;
    logic [VC_ADDRESS_WIDTH-1:0] f_vc;
    logic                        accept;

    assign f_valid   = data_in[WIDTH_FLIT-1];
    assign f_head    = data_in[WIDTH_FLIT-2];
    assign f_tail    = data_in[WIDTH_FLIT-3];
    assign f_vc      = data_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];

    // Assembly also pauses while a held word is blocked downstream.
    assign ready_out = !out_full || ready_in;
    // Flits with the flit-valid bit clear are consumed but ignored.
    assign accept    = valid_in && ready_out && f_valid;

    assign valid_out = out_full;
    assign body_off  = PH + ((k == 2'd0) ? 0 : (int'(k) - 1)) * PB;
    assign vc_pkt    = (state == ST_IDLE || f_head) ? f_vc : vc_hold;
    assign unused_asm = ^assembled;

    // Stored chunks with the incoming flit's chunk overlaid at its slot.
    always_comb begin
        assembled = payload;
        if (state == ST_BODY && !f_head) begin
            assembled[body_off +: PB] = data_in[PB-1:0];
        end else begin
            assembled[PH-1:0] = data_in[PH-1:0];
        end
    end

    // Next-state logic: tail must be set exactly on the last flit index.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        store_head = 1'b0;
        store_body = 1'b0;
        load       = 1'b0;
        err        = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!f_head || (f_tail != HEAD_LAST)) begin
                        err = 1'b1;
                    end else if (HEAD_LAST) begin
                        load = 1'b1;
                    end else begin
                        store_head = 1'b1;
                        k_nxt      = 2'd1;
                        state_nxt  = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (f_head) begin
                        // Abandon the partial packet and restart on this head.
                        err = 1'b1;
                        if (f_tail) begin
                            state_nxt = ST_IDLE;
                            k_nxt     = 2'd0;
                        end else begin
                            store_head = 1'b1;
                            k_nxt      = 2'd1;
                        end
                    end else if (f_tail != (k == K_LAST)) begin
                        err       = 1'b1;
                        state_nxt = ST_IDLE;
                        k_nxt     = 2'd0;
                    end else if (k == K_LAST) begin
                        load      = 1'b1;
                        state_nxt = ST_IDLE;
                        k_nxt     = 2'd0;
                    end else begin
                        store_body = 1'b1;
                        k_nxt      = k + 2'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    k_nxt     = 2'd0;
                end
            endcase
        end
    end

    // FSM state and flit index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= 2'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Partial payload and head VC capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            payload <= '0;
            vc_hold <= '0;
        end else begin
            if (store_head) begin
                payload[PH-1:0] <= data_in[PH-1:0];
                vc_hold         <= f_vc;
            end
            if (store_body) begin
                payload[body_off +: PB] <= data_in[PB-1:0];
            end
        end
    end

    // Output holding register and registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_full  <= 1'b0;
            data_out  <= '0;
            tag_out   <= '0;
            vc_out    <= '0;
            error_out <= 1'b0;
        end else begin
            error_out <= err;
            if (load) begin
                out_full <= 1'b1;
                data_out <= assembled[WIDTH_DATA-1:0];
                tag_out  <= assembled[WIDTH_DATA +: WIDTH_TAG];
                vc_out   <= vc_pkt;
            end else if (ready_in) begin
                out_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_depacketizer_ta.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_depacketizer_ta
// Description : Directed bench: single-flit instance (defaults) and a
//               three-flit instance (12-bit flits, 16-bit data, 4-bit tag).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_depacketizer_ta;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: defaults, one flit per packet
    logic [35:0] a_data_in;
    logic        a_valid_in, a_ready_out, a_valid_out, a_ready_in, a_error_out;
    logic [11:0] a_data_out;
    logic [7:0]  a_tag_out;
    logic [0:0]  a_vc_out;

    // Instance B: three flits per packet
    logic [11:0] b_data_in;
    logic        b_valid_in, b_ready_out, b_valid_out, b_ready_in, b_error_out;
    logic [15:0] b_data_out;
    logic [3:0]  b_tag_out;
    logic [0:0]  b_vc_out;

    int checks = 0;
    int errors = 0;

    depacketizer_ta u_a (
        .clk(clk), .rst(rst), .data_in(a_data_in), .valid_in(a_valid_in),
        .ready_out(a_ready_out), .data_out(a_data_out), .tag_out(a_tag_out),
        .vc_out(a_vc_out), .valid_out(a_valid_out), .ready_in(a_ready_in),
        .error_out(a_error_out)
    );

    depacketizer_ta #(
        .WIDTH_FLIT(12), .PACKETIZER_WIDTH(3), .WIDTH_DATA(16), .WIDTH_TAG(4)
    ) u_b (
        .clk(clk), .rst(rst), .data_in(b_data_in), .valid_in(b_valid_in),
        .ready_out(b_ready_out), .data_out(b_data_out), .tag_out(b_tag_out),
        .vc_out(b_vc_out), .valid_out(b_valid_out), .ready_in(b_ready_in),
        .error_out(b_error_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packetizer model for instance B: head {fv,h,t,vc,dst,p[3:0]},
    // body {fv,h,t,vc,p[11:4]}, tail {fv,h,t,vc,p[19:12]}.
    function automatic logic [11:0] bflit(input logic [19:0] w, input logic vc, input int j);
        case (j)
            0:       return {3'b110, vc, 4'h5, w[3:0]};
            1:       return {3'b100, vc, w[11:4]};
            default: return {3'b101, vc, w[19:12]};
        endcase
    endfunction

    task automatic send_pkt_b(input logic [19:0] w, input logic vc);
        for (int j = 0; j < 3; j++) begin
            b_data_in  = bflit(w, vc, j);
            b_valid_in = 1'b1;
            step();
        end
        b_valid_in = 1'b0;
    endtask

    task automatic chk_word_b(input string tag, input logic [19:0] w, input logic vc);
        chk({tag, "_valid"}, 32'(b_valid_out), 32'd1);
        chk({tag, "_data"},  32'(b_data_out),  32'(w[15:0]));
        chk({tag, "_tag"},   32'(b_tag_out),   32'(w[19:16]));
        chk({tag, "_vc"},    32'(b_vc_out),    32'(vc));
    endtask

    logic [19:0] words [3];
    logic        vcs   [3];

    initial begin
        rst = 1'b1;
        a_data_in = '0; a_valid_in = 1'b0; a_ready_in = 1'b1;
        b_data_in = '0; b_valid_in = 1'b0; b_ready_in = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_a_valid", 32'(a_valid_out), 32'd0);
        chk("rst_a_err",   32'(a_error_out), 32'd0);
        chk("rst_a_data",  32'(a_data_out),  32'd0);
        chk("rst_a_tag",   32'(a_tag_out),   32'd0);
        chk("rst_a_vc",    32'(a_vc_out),    32'd0);
        chk("rst_a_ready", 32'(a_ready_out), 32'd1);
        chk("rst_b_valid", 32'(b_valid_out), 32'd0);
        chk("rst_b_err",   32'(b_error_out), 32'd0);
        chk("rst_b_data",  32'(b_data_out),  32'd0);
        chk("rst_b_ready", 32'(b_ready_out), 32'd1);

        // Single-flit packet: vc=1 dst=3 tag=A5 data=3C7
        a_data_in  = {3'b111, 1'b1, 4'h3, 8'h00, 8'hA5, 12'h3C7};
        a_valid_in = 1'b1;
        step();
        a_valid_in = 1'b0;
        chk("single_valid", 32'(a_valid_out), 32'd1);
        chk("single_data",  32'(a_data_out),  32'h3C7);
        chk("single_tag",   32'(a_tag_out),   32'hA5);
        chk("single_vc",    32'(a_vc_out),    32'd1);
        chk("single_err",   32'(a_error_out), 32'd0);
        step();
        chk("single_drain", 32'(a_valid_out), 32'd0);

        // Back-to-back three-flit packets with ready_in held high
        words[0] = 20'hF1234; vcs[0] = 1'b0;
        words[1] = 20'h5ABCD; vcs[1] = 1'b1;
        words[2] = 20'h90E0F; vcs[2] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3; j++) begin
                b_data_in  = bflit(words[p], vcs[p], j);
                b_valid_in = 1'b1;
                step();
                if (j == 2) chk_word_b("b2b", words[p], vcs[p]);
                else        chk("b2b_gap_valid", 32'(b_valid_out), 32'd0);
            end
        end
        b_valid_in = 1'b0;
        step();
        chk("b2b_drain", 32'(b_valid_out), 32'd0);

        // Backpressure: first word held while the second packet waits
        b_ready_in = 1'b0;
        send_pkt_b(20'h12345, 1'b1);
        chk_word_b("bp_first", 20'h12345, 1'b1);
        chk("bp_ready_low", 32'(b_ready_out), 32'd0);
        b_data_in  = bflit(20'hABCDE, 1'b0, 0);
        b_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_ready", 32'(b_ready_out), 32'd0);
            chk("bp_hold_data",  32'(b_data_out),  32'h2345);
            chk("bp_hold_tag",   32'(b_tag_out),   32'h1);
        end
        b_ready_in = 1'b1;
        #1;
        chk("bp_ready_back", 32'(b_ready_out), 32'd1);
        step();
        chk("bp_taken", 32'(b_valid_out), 32'd0);
        b_data_in = bflit(20'hABCDE, 1'b0, 1);
        step();
        b_data_in = bflit(20'hABCDE, 1'b0, 2);
        step();
        b_valid_in = 1'b0;
        chk_word_b("bp_second", 20'hABCDE, 1'b0);
        step();
        chk("bp_drain", 32'(b_valid_out), 32'd0);

        // Stray body flit in IDLE
        b_data_in  = bflit(20'h0BEEF, 1'b1, 1);
        b_valid_in = 1'b1;
        step();
        b_valid_in = 1'b0;
        chk("stray_err",   32'(b_error_out), 32'd1);
        chk("stray_valid", 32'(b_valid_out), 32'd0);
        step();
        chk("stray_err_clear", 32'(b_error_out), 32'd0);
        send_pkt_b(20'h0BEEF, 1'b1);
        chk_word_b("stray_next", 20'h0BEEF, 1'b1);
        step();

        // New head arriving at k=1 restarts assembly
        b_data_in  = bflit(20'h77777, 1'b0, 0);
        b_valid_in = 1'b1;
        step();
        b_data_in = bflit(20'h3C0DE, 1'b1, 0);
        step();
        chk("restart_err",   32'(b_error_out), 32'd1);
        chk("restart_valid", 32'(b_valid_out), 32'd0);
        b_data_in = bflit(20'h3C0DE, 1'b1, 1);
        step();
        chk("restart_err_clear", 32'(b_error_out), 32'd0);
        b_data_in = bflit(20'h3C0DE, 1'b1, 2);
        step();
        b_valid_in = 1'b0;
        chk_word_b("restart_word", 20'h3C0DE, 1'b1);
        step();

        // Tail bit clear on the last flit drops the packet
        b_data_in  = bflit(20'h24680, 1'b0, 0);
        b_valid_in = 1'b1;
        step();
        b_data_in = bflit(20'h24680, 1'b0, 1);
        step();
        b_data_in = bflit(20'h24680, 1'b0, 2) & 12'hDFF;
        step();
        b_valid_in = 1'b0;
        chk("notail_err",   32'(b_error_out), 32'd1);
        chk("notail_valid", 32'(b_valid_out), 32'd0);
        step();

        // Reset after two of three flits
        b_data_in  = bflit(20'h11111, 1'b1, 0);
        b_valid_in = 1'b1;
        step();
        b_data_in = bflit(20'h11111, 1'b1, 1);
        step();
        b_valid_in = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(b_valid_out), 32'd0);
        chk("midrst_err",   32'(b_error_out), 32'd0);
        chk("midrst_data",  32'(b_data_out),  32'd0);
        // Flit with flit-valid clear: consumed, no effect
        b_data_in  = bflit(20'h11111, 1'b1, 1) & 12'h7FF;
        b_valid_in = 1'b1;
        step();
        b_valid_in = 1'b0;
        chk("fv0_err",   32'(b_error_out), 32'd0);
        chk("fv0_valid", 32'(b_valid_out), 32'd0);
        send_pkt_b(20'hCAFE5, 1'b1);
        chk_word_b("after_rst", 20'hCAFE5, 1'b1);
        chk("after_rst_err", 32'(b_error_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
